sysctl_timers: RTL and testbench

Parametrised multi-channel timer bank on the CSR bus. It is the next-generation replacement for the fixed dual timer in the system controller. Each channel adds a prescaler, a per-channel IRQ enable and a sticky pending bit, while keeping the one-shot/auto-reload modes. It drives one pulse per channel plus one level-sensitive aggregate interrupt.

---
 rtl/sysctl_timers_pkg.sv | 32 +++
 rtl/sysctl_timers_if.sv | 10 +
 rtl/sysctl_timer_chan.sv | 112 +++++++++++
 rtl/sysctl_timers.sv | 137 +++++++++++++
 tb/tb_sysctl_timers.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysctl_timers_pkg.sv
// Shared register map and CTRL bit layout for the sysctl_timers bank.
package sysctl_timers_pkg;

  // Per-channel register offsets (csr_a[1:0] with csr_a[5]=0)
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_COMPARE  = 2'd1;
  localparam logic [1:0] REG_COUNTER  = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  // Global register offsets (csr_a[1:0] with csr_a[5]=1)
  localparam logic [1:0] GLB_PENDING = 2'd0;
  localparam logic [1:0] GLB_INFO    = 2'd1;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_PEND  = 3;

  localparam int unsigned MAX_CHANNELS = 8;

  function automatic logic [31:0] ctrl_word(input logic en, input logic ar,
                                            input logic irqen, input logic pend);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]    = en;
    w[CTRL_AR]    = ar;
    w[CTRL_IRQEN] = irqen;
    w[CTRL_PEND]  = pend;
    return w;
  endfunction

endpackage

// File: rtl/sysctl_timers_if.sv
// CSR bus bundle between a bus master and the timer bank.
interface sysctl_timers_if;
  logic [14:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/sysctl_timer_chan.sv
// One timer channel: prescaler, counter with compare match, sticky pending
// and the CSR write port for its four registers.
module sysctl_timer_chan
  import sysctl_timers_pkg::*;
#(
  parameter int unsigned width  = 32,
  parameter int unsigned pwidth = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              we_ctrl,
  input  logic              we_compare,
  input  logic              we_counter,
  input  logic              we_presc,
  input  logic [31:0]       wdata,
  input  logic              pend_clr,
  output logic              en,
  output logic              ar,
  output logic              irqen,
  output logic              pending,
  output logic [width-1:0]  counter,
  output logic [width-1:0]  compare,
  output logic [pwidth-1:0] presc_reload,
  output logic              timer_irq
);

  logic              en_reg, en_next;
  logic              ar_reg, ar_next;
  logic              irqen_reg, irqen_next;
  logic              pending_reg, pending_next;
  logic              timer_irq_reg, timer_irq_next;
  logic [width-1:0]  counter_reg, counter_next;
  logic [width-1:0]  compare_reg, compare_next;
  logic [pwidth-1:0] presc_reload_reg, presc_reload_next;
  logic [pwidth-1:0] presc_cnt_reg, presc_cnt_next;
  logic              tick;
  logic              hit;

  always_comb begin
    tick              = en_reg && (presc_cnt_reg == '0);
    hit               = tick && (counter_reg == compare_reg);
    en_next           = en_reg;
    ar_next           = ar_reg;
    irqen_next        = irqen_reg;
    counter_next      = counter_reg;
    compare_next      = compare_reg;
    presc_reload_next = presc_reload_reg;
    presc_cnt_next    = presc_cnt_reg;
    timer_irq_next    = hit;
    pending_next      = pending_reg & ~pend_clr;

    if (en_reg) begin
      presc_cnt_next = tick ? presc_reload_reg : presc_cnt_reg - pwidth'(1);
    end

    if (hit) begin
      if (ar_reg) counter_next = '0;
      else        en_next      = 1'b0;
    end else if (tick) begin
      counter_next = counter_reg + width'(1);
    end

    // CSR writes are applied after the tick update so that they take priority.
    if (we_ctrl) begin
      en_next    = wdata[CTRL_EN];
      ar_next    = wdata[CTRL_AR];
      irqen_next = wdata[CTRL_IRQEN];
      if (wdata[CTRL_PEND]) pending_next = 1'b0;
      if (wdata[CTRL_EN] && !en_reg) presc_cnt_next = presc_reload_reg;
    end
    if (we_compare) compare_next      = wdata[width-1:0];
    if (we_counter) counter_next      = wdata[width-1:0];
    if (we_presc)   presc_reload_next = wdata[pwidth-1:0];

    // A match in the same cycle as a clear keeps the bit set.
    if (hit) pending_next = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      en_reg           <= 1'b0;
      ar_reg           <= 1'b0;
      irqen_reg        <= 1'b0;
      pending_reg      <= 1'b0;
      timer_irq_reg    <= 1'b0;
      counter_reg      <= '0;
      compare_reg      <= '1;
      presc_reload_reg <= '0;
      presc_cnt_reg    <= '0;
    end else begin
      en_reg           <= en_next;
      ar_reg           <= ar_next;
      irqen_reg        <= irqen_next;
      pending_reg      <= pending_next;
      timer_irq_reg    <= timer_irq_next;
      counter_reg      <= counter_next;
      compare_reg      <= compare_next;
      presc_reload_reg <= presc_reload_next;
      presc_cnt_reg    <= presc_cnt_next;
    end
  end

  assign en           = en_reg;
  assign ar           = ar_reg;
  assign irqen        = irqen_reg;
  assign pending      = pending_reg;
  assign counter      = counter_reg;
  assign compare      = compare_reg;
  assign presc_reload = presc_reload_reg;
  assign timer_irq    = timer_irq_reg;

endmodule

// File: rtl/sysctl_timers.sv
// Multi-channel timer bank on the CSR bus: address decode, registered read
// mux, global PENDING register and the aggregate level interrupt.
module sysctl_timers
  import sysctl_timers_pkg::*;
#(
  parameter logic [4:0]  csr_addr = 5'h0,
  parameter int unsigned ntimers  = 4,
  parameter int unsigned width    = 32,
  parameter int unsigned pwidth   = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  sysctl_timers_if.slave     csr,
  output logic [ntimers-1:0] timer_irq,
  output logic               irq
);

  logic                    sel;
  logic                    glb_region;
  logic [2:0]              chan_idx;
  logic [1:0]              reg_idx;
  logic                    chan_valid;
  logic                    chan_we;
  logic                    pend_we;
  logic [MAX_CHANNELS-1:0] pend_clr;
  logic [MAX_CHANNELS-1:0] en_vec;
  logic [MAX_CHANNELS-1:0] ar_vec;
  logic [MAX_CHANNELS-1:0] irqen_vec;
  logic [MAX_CHANNELS-1:0] pend_vec;
  logic [31:0]             compare_rd [MAX_CHANNELS];
  logic [31:0]             counter_rd [MAX_CHANNELS];
  logic [31:0]             presc_rd   [MAX_CHANNELS];
  logic [31:0]             info_word;
  logic [31:0]             csr_do_reg, csr_do_next;
  logic                    irq_reg;
  logic                    unused_addr;

  assign sel         = (csr.csr_a[14:10] == csr_addr);
  assign glb_region  = csr.csr_a[5];
  assign chan_idx    = csr.csr_a[4:2];
  assign reg_idx     = csr.csr_a[1:0];
  assign chan_valid  = (32'(chan_idx) < ntimers);
  assign chan_we     = sel && csr.csr_we && !glb_region && chan_valid;
  assign pend_we     = sel && csr.csr_we && glb_region && (reg_idx == GLB_PENDING);
  assign pend_clr    = pend_we ? csr.csr_di[MAX_CHANNELS-1:0] : '0;
  assign info_word   = {8'd0, 8'(pwidth), 8'(width), 8'(ntimers)};
  assign unused_addr = ^csr.csr_a[9:6];

  // Fixed 8-slot arrays keep the 3-bit channel index in range for any ntimers.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CHANNELS; gi++) begin : g_chan
      if (gi < ntimers) begin : g_on
        logic              ch_we;
        logic [width-1:0]  counter_w;
        logic [width-1:0]  compare_w;
        logic [pwidth-1:0] presc_w;

        assign ch_we = chan_we && (chan_idx == 3'(gi));

        sysctl_timer_chan #(
          .width  (width),
          .pwidth (pwidth)
        ) u_chan (
          .sys_clk      (sys_clk),
          .sys_rst      (sys_rst),
          .we_ctrl      (ch_we && (reg_idx == REG_CTRL)),
          .we_compare   (ch_we && (reg_idx == REG_COMPARE)),
          .we_counter   (ch_we && (reg_idx == REG_COUNTER)),
          .we_presc     (ch_we && (reg_idx == REG_PRESCALE)),
          .wdata        (csr.csr_di),
          .pend_clr     (pend_clr[gi]),
          .en           (en_vec[gi]),
          .ar           (ar_vec[gi]),
          .irqen        (irqen_vec[gi]),
          .pending      (pend_vec[gi]),
          .counter      (counter_w),
          .compare      (compare_w),
          .presc_reload (presc_w),
          .timer_irq    (timer_irq[gi])
        );

        assign compare_rd[gi] = 32'(compare_w);
        assign counter_rd[gi] = 32'(counter_w);
        assign presc_rd[gi]   = 32'(presc_w);
      end else begin : g_off
        logic unused_clr;

        assign unused_clr     = pend_clr[gi];
        assign en_vec[gi]     = 1'b0;
        assign ar_vec[gi]     = 1'b0;
        assign irqen_vec[gi]  = 1'b0;
        assign pend_vec[gi]   = 1'b0;
        assign compare_rd[gi] = '0;
        assign counter_rd[gi] = '0;
        assign presc_rd[gi]   = '0;
      end
    end
  endgenerate

  always_comb begin
    csr_do_next = '0;
    if (sel) begin
      if (!glb_region) begin
        if (chan_valid) begin
          case (reg_idx)
            REG_CTRL:     csr_do_next = ctrl_word(en_vec[chan_idx], ar_vec[chan_idx],
                                                  irqen_vec[chan_idx], pend_vec[chan_idx]);
            REG_COMPARE:  csr_do_next = compare_rd[chan_idx];
            REG_COUNTER:  csr_do_next = counter_rd[chan_idx];
            REG_PRESCALE: csr_do_next = presc_rd[chan_idx];
          endcase
        end
      end else begin
        case (reg_idx)
          GLB_PENDING: csr_do_next = {24'd0, pend_vec};
          GLB_INFO:    csr_do_next = info_word;
          default:     csr_do_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_do_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      csr_do_reg <= csr_do_next;
      irq_reg    <= |(pend_vec & irqen_vec);
    end
  end

  assign csr.csr_do = csr_do_reg;
  assign irq        = irq_reg;

endmodule

// File: tb/tb_sysctl_timers.sv
// Directed and randomized CSR traffic for sysctl_timers, checked every cycle
// against a cycle-level reference model of the register/timer behaviour.
module tb_sysctl_timers;
  localparam int NT = 4;
  localparam int W  = 32;
  localparam int PW = 16;
  localparam logic [31:0] PMASK = 32'hFFFF_FFFF >> (32 - PW);

  logic          sys_clk;
  logic          sys_rst;
  logic [NT-1:0] timer_irq;
  logic          irq;

  sysctl_timers_if bus ();

  sysctl_timers #(
    .csr_addr (5'h0),
    .ntimers  (NT),
    .width    (W),
    .pwidth   (PW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .csr       (bus),
    .timer_irq (timer_irq),
    .irq       (irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit            m_en [NT];
  bit            m_ar [NT];
  bit            m_ie [NT];
  bit            m_pd [NT];
  logic [31:0]   m_cnt[NT];
  logic [31:0]   m_cmp[NT];
  logic [31:0]   m_prl[NT];
  logic [31:0]   m_pc [NT];
  logic [NT-1:0] m_tirq;
  logic          m_irq;
  logic [31:0]   m_do;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] ch_addr(input int n, input int r);
    return {5'h0, 4'h0, 1'b0, 3'(n), 2'(r)};
  endfunction

  function automatic logic [14:0] glb_addr(input int r);
    return {5'h0, 4'h0, 1'b1, 3'd0, 2'(r)};
  endfunction

  task automatic m_reset();
    for (int n = 0; n < NT; n++) begin
      m_en[n] = 0; m_ar[n] = 0; m_ie[n] = 0; m_pd[n] = 0;
      m_cnt[n] = '0; m_cmp[n] = '1; m_prl[n] = '0; m_pc[n] = '0;
    end
    m_tirq = '0;
    m_irq  = 1'b0;
    m_do   = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [14:0] a);
    int n;
    logic [31:0] pv;
    n = int'(a[4:2]);
    if (a[14:10] != 5'h0) return '0;
    if (!a[5]) begin
      if (n >= NT) return '0;
      case (a[1:0])
        2'd0: return {28'd0, m_pd[n], m_ie[n], m_ar[n], m_en[n]};
        2'd1: return m_cmp[n];
        2'd2: return m_cnt[n];
        default: return m_prl[n];
      endcase
    end
    pv = '0;
    for (int k = 0; k < NT; k++) pv[k] = m_pd[k];
    if (a[1:0] == 2'd0) return pv;
    if (a[1:0] == 2'd1) return {8'd0, 8'(PW), 8'(W), 8'(NT)};
    return '0;
  endfunction

  // Advance one clock: predict from pre-edge state and inputs, then compare.
  task automatic step();
    bit            ne[NT], na[NT], ni[NT], np[NT];
    logic [31:0]   nc[NT], ncmp[NT], nprl[NT], npc[NT];
    logic [NT-1:0] hit;
    logic [NT-1:0] clr;
    logic [31:0]   rd, di;
    logic          any_irq;
    bit            sel;
    sel = (bus.csr_a[14:10] == 5'h0);
    di  = bus.csr_di;
    rd  = model_read(bus.csr_a);
    any_irq = 1'b0;
    for (int n = 0; n < NT; n++) any_irq |= (m_pd[n] & m_ie[n]);
    clr = (sel && bus.csr_we && bus.csr_a[5] && bus.csr_a[1:0] == 2'd0) ? di[NT-1:0] : '0;
    for (int n = 0; n < NT; n++) begin
      bit tick, wr;
      tick   = m_en[n] && (m_pc[n] == 0);
      hit[n] = tick && (m_cnt[n] == m_cmp[n]);
      ne[n] = m_en[n]; na[n] = m_ar[n]; ni[n] = m_ie[n]; np[n] = m_pd[n];
      nc[n] = m_cnt[n]; ncmp[n] = m_cmp[n]; nprl[n] = m_prl[n]; npc[n] = m_pc[n];
      if (m_en[n]) npc[n] = tick ? m_prl[n] : m_pc[n] - 1;
      if (hit[n]) begin
        if (m_ar[n]) nc[n] = 0;
        else         ne[n] = 0;
      end else if (tick) begin
        nc[n] = m_cnt[n] + 1;
      end
      if (clr[n]) np[n] = 0;
      wr = sel && bus.csr_we && !bus.csr_a[5] && (int'(bus.csr_a[4:2]) == n);
      if (wr) begin
        case (bus.csr_a[1:0])
          2'd0: begin
            ne[n] = di[0]; na[n] = di[1]; ni[n] = di[2];
            if (di[3]) np[n] = 0;
            if (di[0] && !m_en[n]) npc[n] = m_prl[n];
          end
          2'd1: ncmp[n] = di;
          2'd2: nc[n] = di;
          default: nprl[n] = di & PMASK;
        endcase
      end
      if (hit[n]) np[n] = 1;
    end
    @(posedge sys_clk);
    #1;
    if (sys_rst) begin
      m_reset();
    end else begin
      for (int n = 0; n < NT; n++) begin
        m_en[n] = ne[n]; m_ar[n] = na[n]; m_ie[n] = ni[n]; m_pd[n] = np[n];
        m_cnt[n] = nc[n]; m_cmp[n] = ncmp[n]; m_prl[n] = nprl[n]; m_pc[n] = npc[n];
      end
      m_tirq = hit;
      m_irq  = any_irq;
      m_do   = rd;
    end
    chk("timer_irq", 32'(timer_irq), 32'(m_tirq));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("csr_do", bus.csr_do, m_do);
  endtask

  task automatic wr(input logic [14:0] a, input logic [31:0] d);
    bus.csr_a = a; bus.csr_we = 1'b1; bus.csr_di = d;
    step();
    bus.csr_we = 1'b0; bus.csr_di = '0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [31:0] v);
    bus.csr_a = a; bus.csr_we = 1'b0;
    step();
    v = bus.csr_do;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int unsigned op, ch, r;
    logic [31:0] d;

    bus.csr_a = '0; bus.csr_we = 1'b0; bus.csr_di = '0;
    sys_rst = 1'b1;
    m_reset();
    step();
    step();
    sys_rst = 1'b0;
    chk("reset_timer_irq", 32'(timer_irq), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_csr_do", bus.csr_do, 32'h0);

    // Auto-reload: compare=4, presc=0 -> pulse every 5 cycles
    wr(ch_addr(0, 1), 32'd4);
    wr(ch_addr(0, 3), 32'd0);
    wr(ch_addr(0, 0), 32'h7);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("ar_pulse", 32'(timer_irq[0]), 32'((k % 5) == 0));
      chk("ar_irq", 32'(irq), 32'(k >= 6));
    end
    wr(ch_addr(0, 0), 32'h0);
    wr(glb_addr(0), 32'hF);

    // Prescaled one-shot: compare=2, presc=3 -> single pulse 12 cycles on
    wr(ch_addr(1, 1), 32'd2);
    wr(ch_addr(1, 3), 32'd3);
    wr(ch_addr(1, 0), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("os_pulse", 32'(timer_irq[1]), 32'(k == 12));
    end
    rd(ch_addr(1, 0), v); chk("os_ctrl", v, 32'h8);
    rd(ch_addr(1, 2), v); chk("os_counter", v, 32'd2);

    // Pending W1C and irq fall
    wr(ch_addr(1, 0), 32'h4);
    step();
    chk("w1c_irq_high", 32'(irq), 32'h1);
    wr(glb_addr(0), 32'h2);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    step();
    chk("w1c_irq_fall", 32'(irq), 32'h0);
    rd(glb_addr(0), v); chk("w1c_pending", v, 32'h0);

    // W1C landing on the match tick: set wins
    wr(ch_addr(0, 2), 32'd0);
    wr(ch_addr(0, 0), 32'h7);
    idle(4);
    wr(glb_addr(0), 32'h1);
    rd(glb_addr(0), v); chk("w1c_vs_set", v, 32'h1);
    wr(ch_addr(0, 0), 32'h0);

    // Multi-channel
    do_reset();
    for (int n = 0; n < NT; n++) wr(ch_addr(n, 1), 32'(2 * n + 1));
    for (int n = 0; n < NT; n++) wr(ch_addr(n, 0), 32'h7);
    idle(8);
    rd(glb_addr(0), v); chk("multi_pending", v, 32'hF);
    wr(ch_addr(2, 0), 32'h3);
    idle(2);
    chk("multi_mask_irq", 32'(irq), 32'h1);

    // CSR precedence and decode holes
    wr(ch_addr(3, 2), 32'd100);
    rd(ch_addr(3, 2), v); chk("cnt_write_wins", v, 32'd100);
    rd(ch_addr(5, 0), v); chk("chan5_read", v, 32'h0);
    rd(glb_addr(1), v); chk("info", v, 32'h0010_2004);
    rd(15'h0400 | glb_addr(1), v); chk("other_page", v, 32'h0);

    // Reset mid-count
    do_reset();
    wr(ch_addr(0, 1), 32'd10);
    wr(ch_addr(0, 0), 32'h1);
    idle(3);
    do_reset();
    chk("rst_timer_irq", 32'(timer_irq), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(ch_addr(0, 1), v); chk("rst_compare", v, 32'hFFFF_FFFF);
    rd(ch_addr(0, 2), v); chk("rst_counter", v, 32'h0);
    rd(ch_addr(0, 0), v); chk("rst_ctrl", v, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      op = $urandom_range(0, 99);
      ch = $urandom_range(0, 4);
      r  = $urandom_range(0, 3);
      case (r)
        0:       d = 32'($urandom_range(0, 15));
        1:       d = 32'($urandom_range(0, 12));
        2:       d = 32'($urandom_range(0, 12));
        default: d = 32'($urandom_range(0, 3));
      endcase
      if (op < 2) begin
        do_reset();
      end else if (op < 40) begin
        wr(ch_addr(int'(ch), int'(r)), d);
      end else if (op < 48) begin
        wr(glb_addr(0), 32'($urandom_range(0, 15)));
      end else if (op < 52) begin
        wr(15'h0400 | ch_addr(int'(ch), int'(r)), $urandom);
      end else if (op < 60) begin
        rd(glb_addr(int'(r)), v);
      end else begin
        rd(ch_addr(int'(ch), int'(r)), v);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
